// File: rtl/osd_io_sequencer.sv
// Round-robin sequencer putting commands from requesters A and B onto the OSD
// command bus; each command and its payload words go out as one atomic burst.
module osd_io_sequencer #(
  parameter int unsigned STROBE_HI = 1,
  parameter int unsigned STROBE_LO = 1,
  parameter int unsigned GAP       = 2,
  parameter int unsigned LEN_W     = 13
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             a_req,
  input  logic [7:0]       a_cmd,
  input  logic [LEN_W-1:0] a_len,
  output logic             a_rd,
  input  logic [15:0]      a_dat,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [7:0]       b_cmd,
  input  logic [LEN_W-1:0] b_len,
  output logic             b_rd,
  input  logic [15:0]      b_dat,
  output logic             b_ack,
  output logic             io_osd,
  output logic             io_strobe,
  output logic [15:0]      io_din,
  output logic             busy
);

  localparam int unsigned CNT_MAX_HL = (STROBE_HI > STROBE_LO) ? STROBE_HI : STROBE_LO;
  localparam int unsigned CNT_MAX    = (CNT_MAX_HL > GAP) ? CNT_MAX_HL : GAP;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_HI     = 3'd2;
  localparam logic [2:0] S_LO     = 3'd3;
  localparam logic [2:0] S_FETCH  = 3'd4;
  localparam logic [2:0] S_SAMPLE = 3'd5;
  localparam logic [2:0] S_END    = 3'd6;
  localparam logic [2:0] S_HOLD   = 3'd7;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             side, side_nxt;      // 1 = B granted
  logic             last_b, last_b_nxt;  // 1 = B was granted last
  logic [15:0]      din_nxt;
  logic             osd_nxt, strobe_nxt, busy_nxt;
  logic             a_rd_nxt, b_rd_nxt, a_ack_nxt, b_ack_nxt;
  logic             grant_a, grant_b;

  // Next state plus next value of every registered output
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rem_nxt    = rem;
    side_nxt   = side;
    last_b_nxt = last_b;
    din_nxt    = io_din;
    grant_a    = a_req && (!b_req || last_b);
    grant_b    = b_req && (!a_req || !last_b);
    case (state)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          state_nxt = S_CMD;
          side_nxt  = grant_b;
          din_nxt   = {8'h00, (grant_b ? b_cmd : a_cmd)};
          rem_nxt   = grant_b ? b_len : a_len;
        end
      end
      S_CMD: begin
        state_nxt = S_HI;
        cnt_nxt   = '0;
      end
      S_HI: begin
        if (cnt == CNT_W'(STROBE_HI - 1)) begin
          state_nxt = S_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_LO: begin
        if (cnt == CNT_W'(STROBE_LO - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (rem != '0) ? S_FETCH : S_END;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_FETCH: begin
        state_nxt = S_SAMPLE;
        if (rem != '0) rem_nxt = rem - LEN_W'(1);
      end
      // read data arrives one cycle after the rd pulse
      S_SAMPLE: begin
        state_nxt = S_HI;
        din_nxt   = side ? b_dat : a_dat;
      end
      S_END: begin
        last_b_nxt = side;
        cnt_nxt    = '0;
        state_nxt  = (GAP > 1) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (cnt == CNT_W'(GAP - 2)) state_nxt = S_IDLE;
        else                        cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
    osd_nxt    = (state_nxt == S_CMD) || (state_nxt == S_HI) || (state_nxt == S_LO) ||
                 (state_nxt == S_FETCH) || (state_nxt == S_SAMPLE);
    strobe_nxt = (state_nxt == S_HI);
    busy_nxt   = (state_nxt != S_IDLE);
    a_rd_nxt   = (state_nxt == S_FETCH) && !side_nxt;
    b_rd_nxt   = (state_nxt == S_FETCH) &&  side_nxt;
    a_ack_nxt  = (state_nxt == S_END)   && !side_nxt;
    b_ack_nxt  = (state_nxt == S_END)   &&  side_nxt;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      side      <= 1'b0;
      last_b    <= 1'b1;
      io_din    <= '0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      busy      <= 1'b0;
      a_rd      <= 1'b0;
      b_rd      <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rem       <= rem_nxt;
      side      <= side_nxt;
      last_b    <= last_b_nxt;
      io_din    <= din_nxt;
      io_osd    <= osd_nxt;
      io_strobe <= strobe_nxt;
      busy      <= busy_nxt;
      a_rd      <= a_rd_nxt;
      b_rd      <= b_rd_nxt;
      a_ack     <= a_ack_nxt;
      b_ack     <= b_ack_nxt;
    end
  end

endmodule
